// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC owner with single-outstanding imem request, pre-decode prediction and RAS control
module fetch_pc_gen #(
    parameter int                 XLEN_PC  = 32,
    parameter logic [XLEN_PC-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN_PC-1:0] imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN_PC-1:0] redirect_pc,
    input  logic               stall,
    output logic               out_valid,
    output logic [XLEN_PC-1:0] out_pc,
    output logic [31:0]        out_instr,
    output logic               out_pred_taken,
    output logic [XLEN_PC-1:0] out_pred_target,
    output logic               ras_push,
    output logic               ras_pop,
    output logic [XLEN_PC-1:0] ras_wdata,
    input  logic [XLEN_PC-1:0] ras_rdata,
    input  logic               ras_valid,
    input  logic               ras_empty,
    input  logic               ras_full
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t             state, state_next;
    logic [XLEN_PC-1:0] pc, pc_next, hold_pc;
    logic [31:0]        hold_instr;
    logic               capture;

    logic [6:0]         opcode;
    logic [4:0]         rd, rs1;
    logic               link_rd, link_rs1;
    logic [XLEN_PC-1:0] j_imm, b_imm, seq_pc;
    logic               pred_taken, want_push, want_pop, accept;
    logic [XLEN_PC-1:0] pred_target;

    assign opcode   = hold_instr[6:0];
    assign rd       = hold_instr[11:7];
    assign rs1      = hold_instr[19:15];
    assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign j_imm    = {{(XLEN_PC-21){hold_instr[31]}}, hold_instr[31], hold_instr[19:12],
                       hold_instr[20], hold_instr[30:21], 1'b0};
    assign b_imm    = {{(XLEN_PC-13){hold_instr[31]}}, hold_instr[31], hold_instr[7],
                       hold_instr[30:25], hold_instr[11:8], 1'b0};
    assign seq_pc   = hold_pc + XLEN_PC'(4);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = seq_pc;
        want_push   = 1'b0;
        want_pop    = 1'b0;
        case (opcode)
            OP_JAL: begin
                pred_taken  = 1'b1;
                pred_target = hold_pc + j_imm;
                want_push   = 1'b1;
            end
            OP_BRANCH: begin
                // backward-taken / forward-not-taken static heuristic
                if (b_imm[XLEN_PC-1]) begin
                    pred_taken  = 1'b1;
                    pred_target = hold_pc + b_imm;
                end
            end
            OP_JALR: begin
                if (link_rd) begin
                    want_push = 1'b1;
                end else if (link_rs1 && !ras_empty) begin
                    want_pop = 1'b1;
                    if (ras_valid) begin
                        pred_taken  = 1'b1;
                        pred_target = ras_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign out_valid       = (state == S_HOLD);
    assign accept          = out_valid && !stall && !redirect_valid;
    assign ras_push        = accept && want_push && !ras_full;
    assign ras_pop         = accept && want_pop;
    assign ras_wdata       = out_valid ? seq_pc : '0;
    assign out_pc          = hold_pc;
    assign out_instr       = hold_instr;
    assign out_pred_taken  = out_valid && pred_taken;
    assign out_pred_target = out_valid ? pred_target : '0;
    assign imem_req_valid  = (state == S_REQ);
    assign imem_addr       = {pc[XLEN_PC-1:2], 2'b00};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ:   if (imem_req_ready) state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    pc_next    = pred_target;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: if (imem_rsp_valid) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
        // an accepted-but-unanswered request must be drained before refetching
        if (redirect_valid) begin
            pc_next = redirect_pc;
            capture = 1'b0;
            case (state)
                S_REQ:   state_next = imem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT:  state_next = imem_rsp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_next = imem_rsp_valid ? S_REQ : S_DRAIN;
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                hold_pc    <= pc;
                hold_instr <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - directed scoreboard bench for fetch_pc_gen
module tb_fetch_pc_gen;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_X1   = 32'h0400_00EF;
    localparam logic [31:0] RET      = 32'h0000_8067;
    localparam logic [31:0] JALR_X1  = 32'h0000_80E7;
    localparam logic [31:0] BEQ_BACK = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_FWD  = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc, out_instr;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;
    logic        ras_push, ras_pop;
    logic [31:0] ras_wdata, ras_rdata;
    logic        ras_valid, ras_empty, ras_full;

    always #5 clk = ~clk;

    fetch_pc_gen #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_wdata(ras_wdata),
        .ras_rdata(ras_rdata), .ras_valid(ras_valid), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] target;
        logic        taken;
        logic        push;
        logic        pop;
    } exp_t;

    exp_t sb[$];
    int tests = 0, fails = 0;
    int pops_seen = 0, pushes_seen = 0, pops_exp = 0, pushes_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic empty, input logic valid, input logic full,
                                   input logic [31:0] top);
        exp_t e;
        int op, rdn, rsn, imm;
        bit lrd, lrs;
        op  = int'(instr & 32'h7F);
        rdn = int'((instr >> 7) & 32'h1F);
        rsn = int'((instr >> 15) & 32'h1F);
        lrd = (rdn == 1) || (rdn == 5);
        lrs = (rsn == 1) || (rsn == 5);
        e.pc = pc; e.instr = instr; e.taken = 1'b0; e.target = pc + 32'd4;
        e.push = 1'b0; e.pop = 1'b0;
        if (op == 'h6F) begin
            imm = (instr[31] ? -(1 << 20) : 0) + (int'(instr[19:12]) << 12)
                + (int'(instr[20]) << 11) + (int'(instr[30:21]) << 1);
            e.taken = 1'b1; e.target = pc + imm; e.push = !full;
        end else if (op == 'h63) begin
            imm = (instr[31] ? -4096 : 0) + (int'(instr[7]) << 11)
                + (int'(instr[30:25]) << 5) + (int'(instr[11:8]) << 1);
            if (imm < 0) begin e.taken = 1'b1; e.target = pc + imm; end
        end else if (op == 'h67) begin
            if (lrd) e.push = !full;
            else if (lrs && !empty) begin
                e.pop = 1'b1;
                if (valid) begin e.taken = 1'b1; e.target = top; end
            end
        end
        return e;
    endfunction

    // acceptance monitor: pops the scoreboard and checks ras strobes every cycle
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (ras_pop) pops_seen++;
        if (ras_push) pushes_seen++;
        if (!rst && out_valid && !stall && !redirect_valid) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_underflow: observed=accept pc %h expected=no accept", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
                chk("pred_taken", {31'd0, out_pred_taken}, {31'd0, e.taken});
                chk("pred_target", out_pred_target, e.target);
                chk("ras_push", {31'd0, ras_push}, {31'd0, e.push});
                chk("ras_pop", {31'd0, ras_pop}, {31'd0, e.pop});
                if (e.push) chk("ras_wdata", ras_wdata, e.pc + 32'd4);
                pops_exp += int'(e.pop);
                pushes_exp += int'(e.push);
            end
        end else begin
            chk("ras_push_idle", {31'd0, ras_push}, 32'd0);
            chk("ras_pop_idle", {31'd0, ras_pop}, 32'd0);
        end
    end

    task automatic wait_req(input logic [31:0] addr, input bit accept);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req_valid && n < 40);
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("imem_addr", imem_addr, addr);
        if (accept) imem_req_ready = 1'b1;
    endtask

    task automatic respond(input logic [31:0] instr, input logic [31:0] pc, input bit keep);
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("out_valid_before_rsp", {31'd0, out_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rdata = instr;
        if (keep) sb.push_back(model(pc, instr, ras_empty, ras_valid, ras_full, ras_rdata));
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("out_valid_after_rsp", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        ras_rdata = '0; ras_valid = 1'b0; ras_empty = 1'b1; ras_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h100);
        chk("rst_pred_target", out_pred_target, 32'd0);
        chk("rst_ras_wdata", ras_wdata, 32'd0);
        rst = 1'b0;

        // sequential fetch, then JAL with push
        wait_req(32'h100, 1); respond(NOP, 32'h100, 1);
        wait_req(32'h104, 1); respond(NOP, 32'h104, 1);
        wait_req(32'h108, 1); respond(JAL_X1, 32'h108, 1);
        wait_req(32'h148, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk); redirect_valid = 1'b0;

        // return with stall: single pop in release cycle
        ras_empty = 1'b0; ras_valid = 1'b1; ras_rdata = 32'h104;
        wait_req(32'h200, 1);
        stall = 1'b1;
        respond(RET, 32'h200, 1);
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold_target", out_pred_target, 32'h104);
        end
        stall = 1'b0;
        wait_req(32'h104, 1);

        // return with empty ras, JAL with full ras
        ras_empty = 1'b1; ras_valid = 1'b0;
        respond(RET, 32'h104, 1);
        wait_req(32'h108, 1);
        ras_full = 1'b1;
        respond(JAL_X1, 32'h108, 1);
        wait_req(32'h148, 0);
        ras_full = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk); redirect_valid = 1'b0;

        // branches and linking JALR
        wait_req(32'h300, 1); respond(BEQ_BACK, 32'h300, 1);
        wait_req(32'h2F8, 1); respond(BEQ_FWD, 32'h2F8, 1);
        ras_empty = 1'b0; ras_valid = 1'b1;
        wait_req(32'h2FC, 1); respond(JALR_X1, 32'h2FC, 1);
        ras_empty = 1'b1; ras_valid = 1'b0;

        // redirect while WAIT: response drained
        wait_req(32'h300, 1);
        @(negedge clk);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h800;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rdata = JAL_X1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // redirect while HOLD overrides acceptance of a JAL
        wait_req(32'h800, 1);
        stall = 1'b1;
        respond(JAL_X1, 32'h800, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h900; stall = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("hold_redirect_out_valid", {31'd0, out_valid}, 32'd0);

        // response coinciding with redirect in WAIT
        wait_req(32'h900, 1);
        @(negedge clk);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = NOP;
        redirect_valid = 1'b1; redirect_pc = 32'hA00;
        @(negedge clk);
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        chk("coincide_out_valid", {31'd0, out_valid}, 32'd0);
        wait_req(32'hA00, 0);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); redirect_valid = 1'b0;
        wait_req(32'hFFFF_FFFC, 1); respond(NOP, 32'hFFFF_FFFC, 1);
        wait_req(32'h0, 1);

        // reset mid-flight; late response ignored
        @(negedge clk);
        imem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h100);
        imem_rsp_valid = 1'b1; imem_rdata = JAL_X1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("late_rsp_out_valid", {31'd0, out_valid}, 32'd0);
        wait_req(32'h100, 1); respond(NOP, 32'h100, 1);
        wait_req(32'h104, 0);

        @(negedge clk);
        #3;
        chk("pop_count", pops_seen, pops_exp);
        chk("push_count", pushes_seen, pushes_exp);
        chk("pop_count_abs", pops_seen, 32'd1);
        chk("push_count_abs", pushes_seen, 32'd2);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Stage-1 fetch front end that owns the PC and issues one word fetch at a time to instruction memory. It pre-decodes each returned instruction to predict control flow: JAL, backward conditional branches, and returns. It drives the push/pop/data interface of the return address stack (ras) in the same stage. Accepted instructions pass to decode with their PC and prediction; backend redirects override everything.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
XLEN_PC, 32, PC/address width. Matches ras data width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_addr  out  32  fetch address (word aligned)
imem_rsp_valid  in  1  response data valid
imem_rdata  in  32  fetched instruction
redirect_valid  in  1  backend mispredict/trap redirect
redirect_pc  in  32  redirect target
stall  in  1  decode cannot accept this cycle
out_valid  out  1  instruction valid to decode
out_pc  out  32  PC of instruction
out_instr  out  32  instruction word
out_pred_taken  out  1  prediction taken
out_pred_target  out  32  predicted next PC
ras_push  out  1  push to ras
ras_pop  out  1  pop from ras
ras_wdata  out  32  push data (out_pc+4)
ras_rdata  in  32  ras top (combinational on pop)
ras_valid  in  1  ras_rdata valid
ras_empty  in  1  ras empty
ras_full  in  1  ras full

Behaviour:
- Only one outstanding request at a time. FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- Reset (rst high at posedge): state=IDLE, pc=RESET_PC. All outputs 0 except imem_addr=RESET_PC. rst mid-operation abandons any outstanding response; a response arriving after reset is ignored.
- IDLE -> REQ after one cycle.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready go to WAIT.
- WAIT: on imem_rsp_valid capture pc/instr into the hold register and go to HOLD. out_valid=1 from the next cycle, giving 1 cycle of latency from response to decode.
- HOLD: out_valid=1 and out_* are stable while stall=1. The instruction is accepted when out_valid & !stall. On acceptance pc=out_pred_target and the FSM goes to REQ.
- Pre-decode is combinational on the held instruction. link(r) means r==x1 or r==x5.
  - JAL (opcode 1101111): taken, target=out_pc+sext(J-imm).
  - BRANCH (1100011): taken only if B-imm<0, target=out_pc+sext(B-imm). Otherwise out_pc+4.
  - JALR (1100111) with link(rd): push only, predict not taken. No pop, even if link(rs1).
  - JALR with !link(rd) && link(rs1) is a return. If !ras_empty, pop and take ras_rdata as the target (taken=1, requires ras_valid). If ras_empty, not taken, target=out_pc+4.
  - Any other JALR: not taken. All else: not taken, target=out_pc+4.
  - Push on JAL or JALR with link(rd). ras_wdata=out_pc+4.
- ras_push and ras_pop are asserted only in the acceptance cycle (out_valid & !stall & !redirect_valid). Each is a single-cycle pulse per instruction, so a stall never double-pops or double-pushes. ras_push is suppressed when ras_full (the entry is dropped). ras_push and ras_pop are never both high.
- Redirect has priority over everything, including acceptance. No ras ops occur in a redirect cycle, and pc=redirect_pc.
  - In REQ: if imem_req_ready is high that cycle, go to DRAIN. Otherwise stay in REQ with the new address.
  - In WAIT: go to DRAIN.
  - In HOLD: the held instruction is discarded, out_valid=0 next cycle, then REQ.
  - In DRAIN: discard the next imem_rsp_valid, then REQ. A redirect while in DRAIN updates pc and stays in DRAIN.
- If imem_rsp_valid coincides with redirect_valid in WAIT, the response is discarded and the FSM goes to REQ.
- PC arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal.

Test Plan:
- Reset with RESET_PC=0x100, imem ready and 1-cycle response -> first imem_addr=0x100, then 0x104, 0x108. out_valid rises 1 cycle after each response.
- JAL x1,+0x40 (0x040000EF) at 0x100 -> out_pred_taken=1, target=0x140. ras_push pulses once with ras_wdata=0x104. Next imem_addr=0x140.
- ret (0x00008067) at 0x200, ras non-empty with top 0x104, stall held 3 cycles then released -> ras_pop pulses exactly once, in the release cycle. target=0x104. Next fetch=0x104.
- ret with ras_empty=1 -> ras_pop=0, out_pred_taken=0, target=0x204.
- BEQ x0,x0,-8 (0xFE000CE3) at 0x300 -> taken, target=0x2F8. The forward branch variant gives not taken, target=0x304.
- redirect_valid with redirect_pc=0x800 while in WAIT -> the pending response is dropped (out_valid stays 0) and the next imem_addr=0x800. The same redirect while HOLD with JAL held -> no ras_push, and out_valid=0 next cycle.
